// File: rtl/ap_ctrl_txn_probe_if.sv
// ap_ctrl handshake taps plus record stream of one ap_ctrl_txn_probe instance.
// slave: the probe side; master: the environment driving the taps and consuming records.
interface ap_ctrl_txn_probe_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ID_W  = 16
);
  logic                      ap_start;
  logic                      ap_ready;
  logic                      ap_done;
  logic                      ap_continue;
  logic                      finish;
  logic                      rec_valid;
  logic                      rec_ready;
  logic [ID_W+3*CNT_W-1:0]   rec_data;
  logic [15:0]               drop_cnt;
  logic [1:0]                err_flags;
  logic                      drained;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    input  rec_valid, rec_data, drop_cnt, err_flags, drained
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    output rec_valid, rec_data, drop_cnt, err_flags, drained
  );
endinterface

// File: rtl/ap_ctrl_txn_probe.sv
// Passive ap_ctrl transaction probe: timestamps accepted starts and completed dones,
// pairs them oldest-first and emits {id, start_ts, latency, interval} records.
module ap_ctrl_txn_probe #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ID_W       = 16,
  parameter int unsigned PEND_DEPTH = 8,
  parameter int unsigned OUT_DEPTH  = 16
) (
  input  logic               clock,
  input  logic               reset,
  ap_ctrl_txn_probe_if.slave bus
);

  localparam int unsigned PA_W  = $clog2(PEND_DEPTH);
  localparam int unsigned OA_W  = $clog2(OUT_DEPTH);
  localparam int unsigned REC_W = ID_W + 3 * CNT_W;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic               drained_q;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic [CNT_W-1:0]   pend_mem [PEND_DEPTH];
  logic [PA_W-1:0]    pend_rd_q, pend_rd_d;
  logic [PA_W-1:0]    pend_wr_q, pend_wr_d;
  logic [PA_W:0]      pend_cnt_q, pend_cnt_d;

  logic [CNT_W-1:0]   last_ts_q, last_ts_d;
  logic               have_last_q, have_last_d;

  logic               stg_vld_q, stg_vld_d;
  logic [REC_W-1:0]   stg_data_q, stg_data_d;

  logic [REC_W-1:0]   out_mem [OUT_DEPTH];
  logic [OA_W-1:0]    out_rd_q, out_rd_d;
  logic [OA_W-1:0]    out_wr_q, out_wr_d;
  logic [OA_W:0]      out_cnt_q, out_cnt_d;

  logic [15:0]        drop_q, drop_d;
  logic [1:0]         err_q, err_d;

  logic               run, start_ev, done_ev;
  logic               pend_empty, pend_full, pend_push, pend_pop;
  logic               rec_gen;
  logic [CNT_W-1:0]   rec_ts, rec_lat, rec_int;
  logic               out_valid, out_pop, out_full, out_push, out_drop;

  // Event decode, pending-start bookkeeping, record formation and output FIFO control.
  always_comb begin
    run        = (state_q == S_RUN);
    start_ev   = run & bus.ap_start & bus.ap_ready;
    done_ev    = run & bus.ap_done & bus.ap_continue;
    pend_empty = (pend_cnt_q == '0);
    pend_full  = (pend_cnt_q == (PA_W+1)'(PEND_DEPTH));

    // A start coinciding with a done either bypasses (nothing pending) or
    // replaces the popped entry, so it never needs a free slot.
    pend_pop   = done_ev & ~pend_empty;
    pend_push  = start_ev & (done_ev ? ~pend_empty : ~pend_full);
    rec_gen    = done_ev & (~pend_empty | start_ev);

    rec_ts     = pend_empty ? cnt_q : pend_mem[pend_rd_q];
    rec_lat    = cnt_q - rec_ts;
    rec_int    = have_last_q ? (rec_ts - last_ts_q) : '0;

    cnt_d      = cnt_q + CNT_W'(1);
    id_d       = id_q + ID_W'(rec_gen);
    pend_rd_d  = pend_pop  ? pend_rd_q + PA_W'(1) : pend_rd_q;
    pend_wr_d  = pend_push ? pend_wr_q + PA_W'(1) : pend_wr_q;
    pend_cnt_d = pend_cnt_q + (PA_W+1)'(pend_push) - (PA_W+1)'(pend_pop);

    last_ts_d   = rec_gen ? rec_ts : last_ts_q;
    have_last_d = have_last_q | rec_gen;

    stg_vld_d  = rec_gen;
    stg_data_d = stg_data_q;
    if (rec_gen) begin
      stg_data_d = {id_q, rec_ts, rec_lat, rec_int};
    end

    err_d = err_q | {done_ev & pend_empty & ~start_ev,
                     start_ev & ~done_ev & pend_full};

    // A same-cycle pop frees the slot the staged record needs.
    out_valid = (out_cnt_q != '0);
    out_pop   = out_valid & bus.rec_ready;
    out_full  = (out_cnt_q == (OA_W+1)'(OUT_DEPTH));
    out_push  = stg_vld_q & (~out_full | out_pop);
    out_drop  = stg_vld_q & out_full & ~out_pop;
    out_rd_d  = out_pop  ? out_rd_q + OA_W'(1) : out_rd_q;
    out_wr_d  = out_push ? out_wr_q + OA_W'(1) : out_wr_q;
    out_cnt_d = out_cnt_q + (OA_W+1)'(out_push) - (OA_W+1)'(out_pop);

    drop_d = drop_q;
    if (out_drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      id_q        <= '0;
      pend_rd_q   <= '0;
      pend_wr_q   <= '0;
      pend_cnt_q  <= '0;
      last_ts_q   <= '0;
      have_last_q <= 1'b0;
      stg_vld_q   <= 1'b0;
      stg_data_q  <= '0;
      out_rd_q    <= '0;
      out_wr_q    <= '0;
      out_cnt_q   <= '0;
      drop_q      <= '0;
      err_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      pend_rd_q   <= pend_rd_d;
      pend_wr_q   <= pend_wr_d;
      pend_cnt_q  <= pend_cnt_d;
      last_ts_q   <= last_ts_d;
      have_last_q <= have_last_d;
      stg_vld_q   <= stg_vld_d;
      stg_data_q  <= stg_data_d;
      out_rd_q    <= out_rd_d;
      out_wr_q    <= out_wr_d;
      out_cnt_q   <= out_cnt_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  // Pending start timestamp storage; contents are meaningless outside the occupied range.
  always_ff @(posedge clock) begin
    if (pend_push) begin
      pend_mem[pend_wr_q] <= cnt_q;
    end
  end

  // Output record storage.
  always_ff @(posedge clock) begin
    if (out_push) begin
      out_mem[out_wr_q] <= stg_data_q;
    end
  end

  // Run/drain/done sequencing; drained rises together with the edge that empties the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_RUN;
      drained_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (bus.finish) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_cnt_d == '0) begin
            state_q   <= S_DONE;
            drained_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_DONE;
          drained_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rec_valid = out_valid;
  assign bus.rec_data  = out_valid ? out_mem[out_rd_q] : '0;
  assign bus.drop_cnt  = drop_q;
  assign bus.err_flags = err_q;
  assign bus.drained   = drained_q;

endmodule

// File: tb/tb_ap_ctrl_txn_probe.sv
// Bench for ap_ctrl_txn_probe: directed scenarios plus randomized traffic, scored
// against a queue-based transaction model (narrow counter so wrap is reachable).
module tb_ap_ctrl_txn_probe;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ID_W  = 16;
  localparam int unsigned PD    = 8;
  localparam int unsigned OD    = 16;
  localparam int unsigned REC_W = ID_W + 3 * CNT_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ap_ctrl_txn_probe_if #(.CNT_W(CNT_W), .ID_W(ID_W)) bus ();

  ap_ctrl_txn_probe #(
    .CNT_W(CNT_W),
    .ID_W(ID_W),
    .PEND_DEPTH(PD),
    .OUT_DEPTH(OD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // reference model state
  logic [CNT_W-1:0] m_cyc;
  logic [CNT_W-1:0] pend_q[$];
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];
  int               occ;
  bit               stg_v;
  logic [REC_W-1:0] stg;
  int unsigned      m_id;
  bit               have_last;
  logic [CNT_W-1:0] last_ts;
  int unsigned      m_drop;
  logic [1:0]       m_err;
  bit               fin_seen;
  bit               m_drained;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [REC_W-1:0] mk(input int unsigned id, input int unsigned ts,
                                          input int unsigned lat, input int unsigned iv);
    return {ID_W'(id), CNT_W'(ts), CNT_W'(lat), CNT_W'(iv)};
  endfunction

  // Transaction model: one step per clock, written in terms of starts, dones and records.
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_cyc = '0; pend_q.delete(); exp_q.delete(); occ = 0; stg_v = 0; stg = '0;
      m_id = 0; have_last = 0; last_ts = '0; m_drop = 0; m_err = '0;
      fin_seen = 0; m_drained = 0;
    end else begin
      bit was_run, was_drain, st, dn, popped;
      logic [CNT_W-1:0] ts;
      was_run   = !fin_seen;
      was_drain = fin_seen && !m_drained;
      if (occ > 0 && bus.rec_ready) occ--;
      if (stg_v) begin
        if (occ < int'(OD)) begin
          occ++;
          exp_q.push_back(stg);
        end else if (m_drop < 65535) begin
          m_drop++;
        end
        stg_v = 0;
      end
      st = was_run && bus.ap_start && bus.ap_ready;
      dn = was_run && bus.ap_done && bus.ap_continue;
      if (dn) begin
        if (pend_q.size() > 0 || st) begin
          popped = (pend_q.size() > 0);
          ts = popped ? pend_q.pop_front() : m_cyc;
          stg = mk(m_id, ts, m_cyc - ts, have_last ? ts - last_ts : 0);
          stg_v = 1;
          m_id++;
          last_ts = ts;
          have_last = 1;
          if (st && popped) pend_q.push_back(m_cyc);
        end else begin
          m_err[1] = 1'b1;
        end
      end else if (st) begin
        if (pend_q.size() < PD) pend_q.push_back(m_cyc);
        else m_err[0] = 1'b1;
      end
      if (was_run && bus.finish) fin_seen = 1;
      if (was_drain && occ == 0) m_drained = 1;
      m_cyc = m_cyc + 1'b1;
    end
  end

  // Monitor: per-cycle status checks and scoreboard pop on each record transfer.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      check("rec_valid", 64'(bus.rec_valid), 64'(occ > 0));
      check("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
      check("err_flags", 64'(bus.err_flags), 64'(m_err));
      check("drained", 64'(bus.drained), 64'(m_drained));
      if (bus.rec_valid && bus.rec_ready) begin
        if (exp_q.size() == 0) begin
          check("rec_unexpected", 64'(bus.rec_data), 64'h0);
          if (bus.rec_data == '0) begin
            n_err++;
            $display("FAIL rec_unexpected: got record 0x0, expected none at %0t", $time);
          end
        end else begin
          check("rec_data", 64'(bus.rec_data), 64'(exp_q.pop_front()));
        end
        got_q.push_back(bus.rec_data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ap_start = 0; bus.ap_ready = 1; bus.ap_done = 0; bus.ap_continue = 1;
    bus.finish = 0; bus.rec_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    got_q.delete();
  endtask

  task automatic go_to(input int unsigned c);
    int unsigned k = 0;
    while (m_cyc != CNT_W'(c) && k < 600) begin
      tick();
      k++;
    end
    if (k >= 600) check("go_to_timeout", 64'(m_cyc), 64'(c));
  endtask

  task automatic wait_recs(input int unsigned n, input string name);
    int unsigned k = 0;
    while (got_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    check(name, 64'(got_q.size()), 64'(n));
  endtask

  initial begin
    idle_inputs();

    // single transaction: start at 10, done at 17
    do_reset();
    check("reset_valid", 64'(bus.rec_valid), 64'h0);
    check("reset_data", 64'(bus.rec_data), 64'h0);
    go_to(10); bus.ap_start = 1; tick(); bus.ap_start = 0;
    go_to(17); bus.ap_done = 1; tick(); bus.ap_done = 0;
    check("t1_valid_c18", 64'(bus.rec_valid), 64'h0);
    tick();
    check("t1_valid_c19", 64'(bus.rec_valid), 64'h1);
    wait_recs(1, "t1_count");
    if (got_q.size() >= 1) check("t1_rec", 64'(got_q[0]), 64'(mk(0, 10, 7, 0)));

    // pipelined: starts 5,6,7; dones 12,13,14
    do_reset();
    go_to(5); bus.ap_start = 1; go_to(8); bus.ap_start = 0;
    go_to(12); bus.ap_done = 1; go_to(15); bus.ap_done = 0;
    wait_recs(3, "t2_count");
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      check("t2_rec", 64'(got_q[i]), 64'(mk(i, 5 + i, 7, (i == 0) ? 0 : 1)));

    // pending overflow: 9 starts at 2..10, then 8 dones at 12..19
    do_reset();
    go_to(2); bus.ap_start = 1; go_to(11); bus.ap_start = 0;
    check("t3_err_start", 64'(bus.err_flags), 64'h1);
    go_to(12); bus.ap_done = 1; go_to(20); bus.ap_done = 0;
    wait_recs(8, "t3_count");
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check("t3_rec", 64'(got_q[i]), 64'(mk(i, 2 + i, 10, (i == 0) ? 0 : 1)));
    go_to(25); bus.ap_done = 1; tick(); bus.ap_done = 0; tick();
    check("t3_err_both", 64'(bus.err_flags), 64'h3);

    // output FIFO overflow: 20 bypass transactions with rec_ready low
    do_reset();
    bus.rec_ready = 0;
    go_to(3); bus.ap_start = 1; bus.ap_done = 1;
    go_to(23); bus.ap_start = 0; bus.ap_done = 0;
    go_to(27);
    check("t4_drop", 64'(bus.drop_cnt), 64'd4);
    bus.rec_ready = 1;
    wait_recs(16, "t4_count");
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check("t4_rec", 64'(got_q[i]), 64'(mk(i, 3 + i, 0, (i == 0) ? 0 : 1)));

    // counter wrap: start at 254, done 4 cycles later at 2
    do_reset();
    go_to(254); bus.ap_start = 1; tick(); bus.ap_start = 0;
    go_to(2); bus.ap_done = 1; tick(); bus.ap_done = 0;
    wait_recs(1, "t5_count");
    if (got_q.size() >= 1) check("t5_rec", 64'(got_q[0]), 64'(mk(0, 254, 4, 0)));

    // finish with records held; events during drain are ignored
    do_reset();
    bus.rec_ready = 0;
    go_to(3); bus.ap_start = 1; go_to(6); bus.ap_start = 0;
    go_to(8); bus.ap_done = 1; go_to(11); bus.ap_done = 0; bus.finish = 1;
    go_to(13); bus.ap_start = 1; bus.ap_done = 1;
    go_to(16); bus.ap_start = 0; bus.ap_done = 0;
    go_to(20);
    check("t6_not_drained", 64'(bus.drained), 64'h0);
    check("t6_err_clear", 64'(bus.err_flags), 64'h0);
    bus.rec_ready = 1;
    wait_recs(3, "t6_count");
    check("t6_drained_next", 64'(bus.drained), 64'h1);
    repeat (4) tick();
    check("t6_no_extra", 64'(got_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      check("t6_rec", 64'(got_q[i]), 64'(mk(i, 3 + i, 5, (i == 0) ? 0 : 1)));

    // asynchronous reset mid-stream
    do_reset();
    bus.rec_ready = 0;
    go_to(3); bus.ap_start = 1; bus.ap_done = 1;
    go_to(6); bus.ap_start = 0;
    tick(); bus.ap_done = 0;
    go_to(12);
    check("t7_pre_valid", 64'(bus.rec_valid), 64'h1);
    check("t7_pre_err", 64'(bus.err_flags), 64'h2);
    #3 reset = 1;
    #1;
    check("t7_rst_valid", 64'(bus.rec_valid), 64'h0);
    check("t7_rst_data", 64'(bus.rec_data), 64'h0);
    check("t7_rst_drop", 64'(bus.drop_cnt), 64'h0);
    check("t7_rst_err", 64'(bus.err_flags), 64'h0);
    check("t7_rst_drained", 64'(bus.drained), 64'h0);

    // randomized traffic with varying start/done/ready densities
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int unsigned ps, pdn, pr;
      ps  = $urandom_range(10, 90);
      pdn = $urandom_range(10, 90);
      pr  = $urandom_range(5, 95);
      if (blk == 7) begin
        #3 reset = 1;
        tick();
        tick();
        reset = 0;
      end
      repeat (200) begin
        bus.ap_start    = ($urandom_range(0, 99) < ps);
        bus.ap_ready    = ($urandom_range(0, 99) < 80);
        bus.ap_done     = ($urandom_range(0, 99) < pdn);
        bus.ap_continue = ($urandom_range(0, 99) < 80);
        bus.rec_ready   = ($urandom_range(0, 99) < pr);
        tick();
      end
    end
    bus.finish = 1;
    bus.rec_ready = 1;
    begin
      int unsigned k = 0;
      while (!m_drained && k < 200) begin
        tick();
        k++;
      end
    end
    tick();
    check("final_drained", 64'(bus.drained), 64'h1);
    check("final_scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
